// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per
// clock through a carry register, with valid/ready handshakes on both sides.

module serial_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] r,
  output logic             cout,
  output logic             msb_cin
);
  assign {cout, r} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  // Carry into the top bit recovered from the sum bit: r = a ^ b ^ cin at the MSB.
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ r[CHUNK-1];
endmodule

module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [CHUNK-1:0] a_k, b_k, r_k;
  logic             c_k, msb_cin;

  assign a_k = a_q[cnt*CHUNK +: CHUNK];
  assign b_k = b_q[cnt*CHUNK +: CHUNK];

  serial_chunk_add #(.CHUNK(CHUNK)) u_add (
    .a       (a_k),
    .b       (b_k),
    .cin     (carry),
    .r       (r_k),
    .cout    (c_k),
    .msb_cin (msb_cin)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtraction runs as a + ~b + 1: invert b here, seed carry with sub.
          state <= RUN;
          a_q   <= a;
          b_q   <= b ^ {WIDTH{sub}};
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          sum[cnt*CHUNK +: CHUNK] <= r_k;
          carry <= c_k;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NCHUNK - 1)) begin
            state <= DONE;
            cout  <= c_k;
            ovf   <= msb_cin ^ c_k;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
